// File: rtl/gray_counter.sv
// gray_counter: registered binary/Gray up/down counter with load, wrap pulse,
// per-step Gray change mask and combinational terminal count.
module gray_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] chg,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal  = '1;
  localparam logic [WIDTH-1:0] ZeroVal = '0;
  localparam bit               WrapEn  = (WRAP != 0);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] chg_q,  chg_d;
  logic             wrap_q, wrap_d;
  logic             step;

  // Next binary value (load > en > hold); Gray and change mask derive from it.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q != MaxVal) begin
          bin_d = bin_q + WIDTH'(1);
          step  = 1'b1;
        end else if (WrapEn) begin
          bin_d  = ZeroVal;
          wrap_d = 1'b1;
          step   = 1'b1;
        end
      end else begin
        if (bin_q != ZeroVal) begin
          bin_d = bin_q - WIDTH'(1);
          step  = 1'b1;
        end else if (WrapEn) begin
          bin_d  = MaxVal;
          wrap_d = 1'b1;
          step   = 1'b1;
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
    chg_d  = step ? (gray_q ^ gray_d) : ZeroVal;
  end

  // State registers; binary and Gray forms update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      chg_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      chg_q  <= chg_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign chg      = chg_q;
  assign wrap     = wrap_q;
  // Terminal count looks at the live direction, no register delay.
  assign tc       = up ? (bin_q == MaxVal) : (bin_q == ZeroVal);

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of a wrapping and a saturating gray_counter.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [3:0] load_val;

  logic [3:0] w_bin, w_gray, w_chg;
  logic       w_wrap, w_tc;
  logic [3:0] s_bin, s_gray, s_chg;
  logic       s_wrap, s_tc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_out(w_bin), .gray_out(w_gray), .chg(w_chg), .wrap(w_wrap), .tc(w_tc)
  );

  gray_counter #(.WIDTH(4), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .bin_out(s_bin), .gray_out(s_gray), .chg(s_chg), .wrap(s_wrap), .tc(s_tc)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input logic [3:0] b, input logic [3:0] g,
                         input logic [3:0] c, input logic wr);
    check_vec({tag, ".w.bin"},  32'(w_bin),  32'(b));
    check_vec({tag, ".w.gray"}, 32'(w_gray), 32'(g));
    check_vec({tag, ".w.chg"},  32'(w_chg),  32'(c));
    check_vec({tag, ".w.wrap"}, 32'(w_wrap), 32'(wr));
  endtask

  task automatic check_s(input string tag, input logic [3:0] b, input logic [3:0] g,
                         input logic [3:0] c, input logic wr);
    check_vec({tag, ".s.bin"},  32'(s_bin),  32'(b));
    check_vec({tag, ".s.gray"}, 32'(s_gray), 32'(g));
    check_vec({tag, ".s.chg"},  32'(s_chg),  32'(c));
    check_vec({tag, ".s.wrap"}, 32'(s_wrap), 32'(wr));
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; en = 1'b0; load_val = v;
    tick();
    load = 1'b0;
  endtask

  // Gray code and change mask after edge k (k = 1..16) of an up count from 0.
  logic [3:0] gray_tbl [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] chg_tbl  [16] = '{4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8,
                                4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8};

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'h0;
    #2;
    check_w("rst", 4'h0, 4'h0, 4'h0, 1'b0);
    check_vec("rst.tc_up", 32'(w_tc), 32'd0);
    up = 1'b0;
    #1;
    check_vec("rst.tc_dn", 32'(w_tc), 32'd1);
    up = 1'b1;
    #8;
    rst_n = 1'b1;

    // Full up count with wrap on the 16th edge.
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        check_vec("up.tc_at_max", 32'(w_tc), 32'd1);
      end
      tick();
      check_w($sformatf("up%0d", k + 1), 4'(k + 1), gray_tbl[k], chg_tbl[k], (k == 15));
      if (k == 15) begin
        check_s("up16", 4'hF, 4'h8, 4'h0, 1'b0);
      end
    end
    en = 1'b0;
    tick();
    check_w("wrap_pulse_end", 4'h0, 4'h0, 4'h0, 1'b0);

    // Down wrap from 0.
    do_load(4'h0);
    en = 1'b1; up = 1'b0;
    #1;
    check_vec("dn.tc_before", 32'(w_tc), 32'd1);
    tick();
    check_w("dnwrap", 4'hF, 4'h8, 4'h8, 1'b1);
    check_s("dnsat",  4'h0, 4'h0, 4'h0, 1'b0);

    // Saturation at max for the non-wrapping counter.
    do_load(4'hF);
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_s($sformatf("sat%0d", k), 4'hF, 4'h8, 4'h0, 1'b0);
      check_vec($sformatf("sat%0d.tc", k), 32'(s_tc), 32'd1);
    end

    // Load wins over en.
    do_load(4'h5);
    load = 1'b1; load_val = 4'hA; en = 1'b1; up = 1'b1;
    tick();
    check_w("ldpri", 4'hA, 4'hF, 4'h0, 1'b0);
    load = 1'b0;
    tick();
    check_w("ldnext", 4'hB, 4'hE, 4'h1, 1'b0);

    // Hold then direction change.
    do_load(4'h6);
    en = 1'b0;
    tick();
    check_w("hold1", 4'h6, 4'h5, 4'h0, 1'b0);
    tick();
    check_w("hold2", 4'h6, 4'h5, 4'h0, 1'b0);
    en = 1'b1; up = 1'b0;
    tick();
    check_w("dirchg", 4'h5, 4'h7, 4'h2, 1'b0);

    // Asynchronous reset between edges.
    do_load(4'h9);
    check_w("preRst", 4'h9, 4'hD, 4'h0, 1'b0);
    en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_w("asyncRst", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    tick();
    check_w("postRst", 4'h1, 4'h1, 4'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
